// File: rtl/cart_map_mux_if.sv
// Bundles every mapper channel's CPU/ROM/BSRAM signals and the single muxed
// result bus that drives the cartridge slot.
//   slave  : the selector (reads the channel buses, drives the muxed bus)
//   master : the mapper side (drives the channel buses, observes the muxed bus)
interface cart_map_mux_if #(
    parameter int unsigned NUM_MAP  = 7,
    parameter int unsigned ROM_AW   = 24,
    parameter int unsigned BSRAM_AW = 20
);
    // per-channel, flattened with channel k at slice k
    logic [8*NUM_MAP-1:0]        ch_do;
    logic [NUM_MAP-1:0]          ch_irq_n;
    logic [ROM_AW*NUM_MAP-1:0]   ch_rom_addr;
    logic [16*NUM_MAP-1:0]       ch_rom_d;
    logic [NUM_MAP-1:0]          ch_rom_ce_n;
    logic [NUM_MAP-1:0]          ch_rom_oe_n;
    logic [NUM_MAP-1:0]          ch_rom_we_n;
    logic [NUM_MAP-1:0]          ch_rom_word;
    logic [BSRAM_AW*NUM_MAP-1:0] ch_bsram_addr;
    logic [8*NUM_MAP-1:0]        ch_bsram_d;
    logic [NUM_MAP-1:0]          ch_bsram_ce_n;
    logic [NUM_MAP-1:0]          ch_bsram_oe_n;
    logic [NUM_MAP-1:0]          ch_bsram_we_n;

    // muxed result
    logic [7:0]          di;
    logic                irq_n;
    logic [ROM_AW-1:0]   rom_addr;
    logic [15:0]         rom_d;
    logic                rom_ce_n;
    logic                rom_oe_n;
    logic                rom_we_n;
    logic                rom_word;
    logic [BSRAM_AW-1:0] bsram_addr;
    logic [7:0]          bsram_d;
    logic                bsram_ce_n;
    logic                bsram_oe_n;
    logic                bsram_we_n;

    modport slave (
        input  ch_do, ch_irq_n, ch_rom_addr, ch_rom_d, ch_rom_ce_n, ch_rom_oe_n,
               ch_rom_we_n, ch_rom_word, ch_bsram_addr, ch_bsram_d,
               ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n,
        output di, irq_n, rom_addr, rom_d, rom_ce_n, rom_oe_n, rom_we_n,
               rom_word, bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n
    );

    modport master (
        output ch_do, ch_irq_n, ch_rom_addr, ch_rom_d, ch_rom_ce_n, ch_rom_oe_n,
               ch_rom_we_n, ch_rom_word, ch_bsram_addr, ch_bsram_d,
               ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n,
        input  di, irq_n, rom_addr, rom_d, rom_ce_n, rom_oe_n, rom_we_n,
               rom_word, bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n
    );
endinterface

// File: rtl/cart_map_mux.sv
// Cartridge mapper output selector. Picks one of NUM_MAP mapper channels
// (channel 0 = default DSP/LoROM/HiROM mapper) to drive the CPU data-in, IRQ,
// ROM bus and BSRAM bus. A channel change drains the outgoing mapper, forces
// an idle gap of SWITCH_GAP+1 cycles, then commits the newest request.
//
// Ports:
//   mclk, rst    master clock, asynchronous active-high reset
//   map_active   one-hot request, bit k selects channel k+1, zero selects 0
//   clr_err      clears the sticky conflict / timeout_err flags
//   bus          cart_map_mux_if.slave: channel buses in, muxed bus out
//   sel          committed channel
//   busy         switch in progress (DRAIN or GAP)
//   turbo_allow  committed channel permits turbo and no switch in progress
//   conflict     sticky: map_active was multi-hot
//   timeout_err  sticky: a drain was forced after DRAIN_TIMEOUT cycles
//
// Optional feature, macro CART_MAP_MUX_STATS_EN: adds switch_cnt (commits,
// saturating) and conflict_cnt (multi-hot cycles, saturating).
module cart_map_mux #(
    parameter int unsigned         NUM_MAP          = 7,
    parameter int unsigned         ROM_AW           = 24,
    parameter int unsigned         BSRAM_AW         = 20,
    parameter int unsigned         SWITCH_GAP       = 4,
    parameter int unsigned         DRAIN_TIMEOUT    = 255,
    parameter logic [NUM_MAP-1:0]  TURBO_BLOCK_MASK = 7'b0010100,
    localparam int unsigned        SEL_W            = (NUM_MAP > 1) ? $clog2(NUM_MAP) : 1
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic [NUM_MAP-2:0]   map_active,
    input  logic                 clr_err,
    cart_map_mux_if.slave        bus,
    output logic [SEL_W-1:0]     sel,
    output logic                 busy,
    output logic                 turbo_allow,
    output logic                 conflict,
    output logic                 timeout_err
`ifdef CART_MAP_MUX_STATS_EN
    ,
    output logic [15:0]          switch_cnt,
    output logic [7:0]           conflict_cnt
`endif
);

    localparam int unsigned DRAIN_W = (DRAIN_TIMEOUT > 0) ? $clog2(DRAIN_TIMEOUT + 1) : 1;
    localparam int unsigned GAP_W   = (SWITCH_GAP > 0) ? $clog2(SWITCH_GAP + 1) : 1;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [SEL_W-1:0]   target;
    logic [SEL_W-1:0]   hot_cnt;
    logic               multi_hot;
    logic               bus_idle;
    logic               drain_clr, drain_inc, gap_load, gap_dec, commit, timeout_set;
    int unsigned        sel_i;

    // Request decode: single hot bit k -> channel k+1; none or several -> 0
    always_comb begin
        hot_cnt = '0;
        target  = '0;
        for (int k = 0; k < NUM_MAP - 1; k++) begin
            if (map_active[k]) begin
                hot_cnt = hot_cnt + SEL_W'(1);
                target  = SEL_W'(k + 1);
            end
        end
        multi_hot = (hot_cnt > SEL_W'(1));
        if (multi_hot) begin
            target = '0;
        end
    end

    assign sel_i    = 32'(sel_q);
    // Only chip enables and ROM write strobe matter for a safe hand-off
    assign bus_idle = bus.ch_rom_ce_n[sel_i] & bus.ch_bsram_ce_n[sel_i] & bus.ch_rom_we_n[sel_i];

    // State register
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACTIVE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        drain_clr   = 1'b0;
        drain_inc   = 1'b0;
        gap_load    = 1'b0;
        gap_dec     = 1'b0;
        commit      = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (target != sel_q) begin
                    state_d   = ST_DRAIN;
                    drain_clr = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (target == sel_q) begin
                    state_d = ST_ACTIVE;
                end else if (bus_idle) begin
                    state_d  = ST_GAP;
                    gap_load = 1'b1;
                end else if (drain_cnt == DRAIN_W'(DRAIN_TIMEOUT)) begin
                    state_d     = ST_GAP;
                    gap_load    = 1'b1;
                    timeout_set = 1'b1;
                end else begin
                    drain_inc = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_d = ST_ACTIVE;
                    commit  = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    // Selection, counters and sticky flags
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            sel_q       <= '0;
            drain_cnt   <= '0;
            gap_cnt     <= '0;
            conflict    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (commit) begin
                sel_q <= target;
            end
            if (drain_clr) begin
                drain_cnt <= '0;
            end else if (drain_inc) begin
                drain_cnt <= drain_cnt + DRAIN_W'(1);
            end
            if (gap_load) begin
                gap_cnt <= GAP_W'(SWITCH_GAP);
            end else if (gap_dec) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
            // set has priority over clear
            if (multi_hot) begin
                conflict <= 1'b1;
            end else if (clr_err) begin
                conflict <= 1'b0;
            end
            if (timeout_set) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

`ifdef CART_MAP_MUX_STATS_EN
    // Saturating switch / conflict statistics
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            switch_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (commit && (switch_cnt != 16'hFFFF)) begin
                switch_cnt <= switch_cnt + 16'd1;
            end
            if (multi_hot) begin
                if (conflict_cnt != 8'hFF) begin
                    conflict_cnt <= conflict_cnt + 8'd1;
                end
            end else if (clr_err) begin
                conflict_cnt <= '0;
            end
        end
    end
`endif

    // Output mux: mirror the committed channel, or drive an idle bus in GAP
    always_comb begin
        bus.di         = 8'hFF;
        bus.irq_n      = 1'b1;
        bus.rom_addr   = '0;
        bus.rom_d      = '0;
        bus.rom_ce_n   = 1'b1;
        bus.rom_oe_n   = 1'b1;
        bus.rom_we_n   = 1'b1;
        bus.rom_word   = 1'b0;
        bus.bsram_addr = '0;
        bus.bsram_d    = '0;
        bus.bsram_ce_n = 1'b1;
        bus.bsram_oe_n = 1'b1;
        bus.bsram_we_n = 1'b1;
        if (state_q != ST_GAP) begin
            bus.di         = bus.ch_do[sel_i*8 +: 8];
            bus.irq_n      = bus.ch_irq_n[sel_i];
            bus.rom_addr   = bus.ch_rom_addr[sel_i*ROM_AW +: ROM_AW];
            bus.rom_d      = bus.ch_rom_d[sel_i*16 +: 16];
            bus.rom_ce_n   = bus.ch_rom_ce_n[sel_i];
            bus.rom_oe_n   = bus.ch_rom_oe_n[sel_i];
            bus.rom_we_n   = bus.ch_rom_we_n[sel_i];
            bus.rom_word   = bus.ch_rom_word[sel_i];
            bus.bsram_addr = bus.ch_bsram_addr[sel_i*BSRAM_AW +: BSRAM_AW];
            bus.bsram_d    = bus.ch_bsram_d[sel_i*8 +: 8];
            bus.bsram_ce_n = bus.ch_bsram_ce_n[sel_i];
            bus.bsram_oe_n = bus.ch_bsram_oe_n[sel_i];
            bus.bsram_we_n = bus.ch_bsram_we_n[sel_i];
        end
    end

    assign sel         = sel_q;
    assign busy        = (state_q != ST_ACTIVE);
    assign turbo_allow = ~TURBO_BLOCK_MASK[sel_i] & ~busy;

endmodule

// File: tb/tb_cart_map_mux.sv
// Directed bench for cart_map_mux: reset pass-through, idle and held-bus
// switches, drain timeout, multi-hot conflict, aborted switch, mid-switch reset.
module tb_cart_map_mux;

    localparam int unsigned NUM_MAP  = 7;
    localparam int unsigned ROM_AW   = 24;
    localparam int unsigned BSRAM_AW = 20;

    logic                mclk = 1'b0;
    logic                rst;
    logic [NUM_MAP-2:0]  map_active;
    logic                clr_err;
    logic [2:0]          sel;
    logic                busy;
    logic                turbo_allow;
    logic                conflict;
    logic                timeout_err;
`ifdef CART_MAP_MUX_STATS_EN
    logic [15:0]         switch_cnt;
    logic [7:0]          conflict_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    cart_map_mux_if #(.NUM_MAP(NUM_MAP), .ROM_AW(ROM_AW), .BSRAM_AW(BSRAM_AW)) bus ();

    cart_map_mux dut (
        .mclk        (mclk),
        .rst         (rst),
        .map_active  (map_active),
        .clr_err     (clr_err),
        .bus         (bus),
        .sel         (sel),
        .busy        (busy),
        .turbo_allow (turbo_allow),
        .conflict    (conflict),
        .timeout_err (timeout_err)
`ifdef CART_MAP_MUX_STATS_EN
        ,
        .switch_cnt  (switch_cnt),
        .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 mclk = ~mclk;

    function automatic logic [23:0] ch_addr(input int k);
        return 24'h123400 + 24'(k) * 24'h010101;
    endfunction

    function automatic logic [7:0] ch_di(input int k);
        return 8'h10 + 8'(k);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    // all channels idle with distinct data
    task automatic init_channels();
        for (int k = 0; k < NUM_MAP; k++) begin
            bus.ch_do[k*8 +: 8]                  = ch_di(k);
            bus.ch_irq_n[k]                      = 1'b1;
            bus.ch_rom_addr[k*ROM_AW +: ROM_AW]  = ch_addr(k);
            bus.ch_rom_d[k*16 +: 16]             = 16'hA000 + 16'(k);
            bus.ch_rom_ce_n[k]                   = 1'b1;
            bus.ch_rom_oe_n[k]                   = 1'b1;
            bus.ch_rom_we_n[k]                   = 1'b1;
            bus.ch_rom_word[k]                   = 1'b1;
            bus.ch_bsram_addr[k*BSRAM_AW +: BSRAM_AW] = 20'h50000 + 20'(k);
            bus.ch_bsram_d[k*8 +: 8]             = 8'h60 + 8'(k);
            bus.ch_bsram_ce_n[k]                 = 1'b1;
            bus.ch_bsram_oe_n[k]                 = 1'b1;
            bus.ch_bsram_we_n[k]                 = 1'b1;
        end
    endtask

    task automatic check_gap(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_di"}, 32'(bus.di), 32'hFF);
        check({tag, "_rom_ce"}, 32'(bus.rom_ce_n), 32'd1);
        check({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
        check({tag, "_rom_word"}, 32'(bus.rom_word), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        map_active = '0;
        clr_err    = 1'b0;
        init_channels();
        step(3);
        rst = 1'b0;
        step(1);

        // reset state and channel 0 pass-through
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'(ch_addr(0)));
        check("rst_di", 32'(bus.di), 32'h10);
        check("rst_turbo", 32'(turbo_allow), 32'd1);
        check("rst_conflict", 32'(conflict), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        bus.ch_rom_ce_n[0] = 1'b0;
        #1;
        check("rst_ce_pass", 32'(bus.rom_ce_n), 32'd0);
        bus.ch_rom_ce_n[0] = 1'b1;

        // idle switch 0 -> 3: one DRAIN cycle, five GAP cycles, commit
        map_active = 6'b000100;
        step(1);
        check("sw3_drain_busy", 32'(busy), 32'd1);
        check("sw3_drain_di", 32'(bus.di), 32'h10);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_gap("sw3_gap");
        end
        step(1);
        check("sw3_sel", 32'(sel), 32'd3);
        check("sw3_busy", 32'(busy), 32'd0);
        check("sw3_turbo", 32'(turbo_allow), 32'd1);
        check("sw3_rom_addr", 32'(bus.rom_addr), 32'(ch_addr(3)));
        check("sw3_rom_d", 32'(bus.rom_d), 32'hA003);

        // back to 0
        map_active = '0;
        step(7);
        check("sw0_sel", 32'(sel), 32'd0);

        // switch 0 -> 2 while ch0 holds the ROM bus for 10 cycles
        bus.ch_rom_ce_n[0] = 1'b0;
        bus.ch_rom_ce_n[2] = 1'b0;
        map_active = 6'b000010;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("hold_ce", 32'(bus.rom_ce_n), 32'd0);
            check("hold_addr", 32'(bus.rom_addr), 32'(ch_addr(0)));
            check("hold_busy", 32'(busy), 32'd1);
        end
        bus.ch_rom_ce_n[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_gap("sw2_gap");
        end
        step(1);
        check("sw2_sel", 32'(sel), 32'd2);
        check("sw2_turbo", 32'(turbo_allow), 32'd0);
        check("sw2_ce_mirror", 32'(bus.rom_ce_n), 32'd0);
        bus.ch_rom_ce_n[2] = 1'b1;

        // 2 -> 1, then ch1 stuck busy while requesting 4
        map_active = 6'b000001;
        step(7);
        check("sw1_sel", 32'(sel), 32'd1);
        bus.ch_rom_ce_n[1] = 1'b0;
        map_active = 6'b001000;
        step(256);
        check("to_pre_err", 32'(timeout_err), 32'd0);
        check("to_pre_sel", 32'(sel), 32'd1);
        check("to_pre_ce", 32'(bus.rom_ce_n), 32'd0);
        step(1);
        check("to_err", 32'(timeout_err), 32'd1);
        check_gap("to_gap");
        step(5);
        check("to_sel", 32'(sel), 32'd4);
        check("to_turbo", 32'(turbo_allow), 32'd0);
        check("to_err_sticky", 32'(timeout_err), 32'd1);
        bus.ch_rom_ce_n[1] = 1'b1;
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("to_clr", 32'(timeout_err), 32'd0);

        // multi-hot request: conflict, target 0
        map_active = 6'b000011;
        step(1);
        check("cf_flag", 32'(conflict), 32'd1);
        check("cf_busy", 32'(busy), 32'd1);
        step(6);
        check("cf_sel", 32'(sel), 32'd0);
        check("cf_busy_done", 32'(busy), 32'd0);
`ifdef CART_MAP_MUX_STATS_EN
        check("cf_cnt", 32'(conflict_cnt), 32'd7);
`endif
        clr_err = 1'b1;
        step(1);
        check("cf_set_wins", 32'(conflict), 32'd1);
        map_active = '0;
        step(1);
        clr_err = 1'b0;
        check("cf_clr", 32'(conflict), 32'd0);
`ifdef CART_MAP_MUX_STATS_EN
        check("cf_cnt_clr", 32'(conflict_cnt), 32'd0);
`endif

        // request 5 then revert during DRAIN: no gap
        map_active = 6'b010000;
        step(1);
        check("ab_busy", 32'(busy), 32'd1);
        check("ab_di", 32'(bus.di), 32'h10);
        map_active = '0;
        step(1);
        check("ab_ret_busy", 32'(busy), 32'd0);
        check("ab_ret_sel", 32'(sel), 32'd0);
        check("ab_ret_di", 32'(bus.di), 32'h10);
        step(1);
        check("ab_no_gap", 32'(busy), 32'd0);
`ifdef CART_MAP_MUX_STATS_EN
        check("ab_switch_cnt", 32'(switch_cnt), 32'd6);
`endif

        // reset in the middle of a switch
        map_active = 6'b000100;
        step(3);
        check("mr_in_gap", 32'(bus.di), 32'hFF);
        rst = 1'b1;
        #1;
        check("mr_sel", 32'(sel), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_di", 32'(bus.di), 32'h10);
        check("mr_rom_addr", 32'(bus.rom_addr), 32'(ch_addr(0)));
        map_active = '0;
        step(1);
        rst = 1'b0;
        step(2);
        check("mr_post_sel", 32'(sel), 32'd0);
        check("mr_post_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
